// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module : cdb_pkg
// Brief  : Shared Common Data Bus widths and broadcast record type.
// Rev    : 1.0  initial release
// ============================================================================
package cdb_pkg;

    localparam int CDB_TAG_WIDTH  = 6;
    localparam int CDB_DATA_WIDTH = 32;

    // Broadcast record consumed by the register status table and the RS.
    typedef struct packed {
        logic                      valid;
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_bus_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational rotating-priority picker: searches from i_ptr upward
//          with wrap-around, emits one-hot grant plus encoded index.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // First pass covers [ptr, N-1]; second pass picks up the wrapped part.
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (i >= int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                o_idx      = IDXW'(i);
                o_valid    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[i]) begin
                o_grant[i] = 1'b1;
                o_idx      = IDXW'(i);
                o_valid    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cdb_arbiter
// Brief  : Common Data Bus producer: one holding entry per functional unit,
//          one registered broadcast per cycle. CDB_ROUND_ROBIN_EN selects
//          round-robin arbitration; otherwise lowest index wins.
// Rev    : 1.0  initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [N_SRC-1:0]            src_valid,
    output logic [N_SRC-1:0]            src_ready,
    input  logic [N_SRC*TAG_WIDTH-1:0]  src_tag,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_data,
    output logic                        cdb_valid,
    output logic [TAG_WIDTH-1:0]        cdb_tag,
    output logic [DATA_WIDTH-1:0]       cdb_data,
    output logic [$clog2(N_SRC)-1:0]    cdb_src
);

    localparam int c_IDXW = $clog2(N_SRC);

    logic [N_SRC-1:0]      r_full;
    logic [TAG_WIDTH-1:0]  r_tag  [N_SRC];
    logic [DATA_WIDTH-1:0] r_data [N_SRC];

    logic                  r_cdb_valid;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [c_IDXW-1:0]     r_cdb_src;

    logic [TAG_WIDTH-1:0]  w_in_tag  [N_SRC];
    logic [DATA_WIDTH-1:0] w_in_data [N_SRC];
    logic [N_SRC-1:0]      w_grant;
    logic [c_IDXW-1:0]     w_gidx;
    logic                  w_gvalid;
    logic [c_IDXW-1:0]     w_ptr;
    logic [N_SRC-1:0]      w_src_ready;
    logic [N_SRC-1:0]      w_take;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
        assign w_in_tag[gi]  = src_tag[gi*TAG_WIDTH +: TAG_WIDTH];
        assign w_in_data[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N    (N_SRC),
        .IDXW (c_IDXW)
    ) u_arb (
        .i_req   (r_full),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

`ifdef CDB_ROUND_ROBIN_EN
    logic [c_IDXW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (!flush && w_gvalid) begin
            r_ptr <= (w_gidx == c_IDXW'(N_SRC - 1)) ? '0 : w_gidx + c_IDXW'(1);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // A granted entry frees up this edge, so it can be refilled concurrently.
    always_comb begin
        w_src_ready = '0;
        if (reset && !flush) begin
            w_src_ready = ~r_full | w_grant;
        end
    end

    assign w_take    = src_valid & w_src_ready;
    assign src_ready = w_src_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full      <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_full      <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_take[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= w_in_tag[i];
                    r_data[i] <= w_in_data[i];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            r_cdb_valid <= w_gvalid;
            if (w_gvalid) begin
                r_cdb_tag  <= r_tag[w_gidx];
                r_cdb_data <= r_data[w_gidx];
                r_cdb_src  <= w_gidx;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire
